shift_seq_ctrl: RTL and testbench

Sequencing controller for the serial shift-register datapath. It accepts a parallel word over a valid/ready handshake and shifts it out one bit per enabled cycle, MSB-first or LSB-first. In the same cycles it captures the serial input and returns the captured word over a second valid/ready handshake. It drives shift_en for the downstream dff chain so that the chain and the controller advance in lockstep.

---
 rtl/shift_seq_ctrl.sv | 162 ++++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: serialises a parallel word one bit per enabled cycle
// (MSB- or LSB-first). In the same cycles it captures the serial input and
// returns the captured word over an output valid/ready handshake. shift_en
// keeps the downstream dff chain in lockstep with the controller.
module shift_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             lsb_first,
    input  logic             hold,
    input  logic             sin,
    output logic             sout,
    output logic             shift_en,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [WIDTH-1:0]   tx_r;
    logic [WIDTH-1:0]   rx_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               order_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   out_data_r;

    logic               accept_s;
    logic               step_s;
    logic               last_s;
    logic [WIDTH-1:0]   tx_next_s;
    logic [WIDTH-1:0]   rx_next_s;

    // The final bit of a word is the one shifted while the counter reads WIDTH-1.
    assign last_s = (cnt_r == CNT_W'(WIDTH - 1));

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

    // Next-state decode plus the combinational handshake/shift outputs.
    always_comb begin
        next_state_s = state_r;
        in_ready     = 1'b0;
        busy         = 1'b0;
        shift_en     = 1'b0;
        sout         = 1'b0;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept_s     = 1'b1;
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = ~hold;
                step_s   = ~hold;
                // The output-end bit stays on sout through hold cycles too.
                if (order_r) begin
                    sout = tx_r[0];
                end else begin
                    sout = tx_r[WIDTH-1];
                end
                if (!hold && last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            DONE: begin
                busy = 1'b1;
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Shifted transmit word and receive word with the current sin folded in.
    always_comb begin
        tx_next_s = tx_r;
        rx_next_s = rx_r;
        if (order_r) begin
            tx_next_s = {1'b0, tx_r[WIDTH-1:1]};
            rx_next_s = {sin, rx_r[WIDTH-1:1]};
        end else begin
            tx_next_s = {tx_r[WIDTH-2:0], 1'b0};
            rx_next_s = {rx_r[WIDTH-2:0], sin};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Word load on accept, then one shift/capture/count per enabled cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_r    <= {WIDTH{1'b0}};
            rx_r    <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            order_r <= 1'b0;
        end else if (accept_s) begin
            tx_r    <= in_data;
            rx_r    <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            order_r <= lsb_first;
        end else if (step_s) begin
            tx_r    <= tx_next_s;
            rx_r    <= rx_next_s;
            cnt_r   <= cnt_r + CNT_W'(1);
        end else begin
            tx_r    <= tx_r;
            rx_r    <= rx_r;
            cnt_r   <= cnt_r;
            order_r <= order_r;
        end
    end

    // Captured-word output register, held until the consumer takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
        end else if (step_s && last_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= rx_next_s;
        end else if ((state_r == DONE) && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl (WIDTH=8): loopback and external-sin
// words in both bit orders, hold stalls, output backpressure and resets.
module tb_shift_seq_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         lsb_first;
    logic         hold;
    logic         sin;
    logic         sout;
    logic         shift_en;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    logic         loop_en;
    logic         sin_drv;

    int total;
    int bad;
    logic [W-1:0] exp_q[$];

    assign sin = loop_en ? sout : sin_drv;

    shift_seq_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .lsb_first (lsb_first),
        .hold      (hold),
        .sin       (sin),
        .sout      (sout),
        .shift_en  (shift_en),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full word: accept, WIDTH shifts (optional hold stall), DONE with
    // optional backpressure, out handshake, back to IDLE.
    task automatic run_word(input logic [W-1:0] data, input logic lsb, input logic loop,
                            input logic [W-1:0] sin_pat, input int hold_at,
                            input int hold_len, input int bp);
        logic [W-1:0] exp_out;
        logic [W-1:0] popped;
        logic         bit_e;
        logic         sbit;
        int           cyc;
        int           en_n;
        exp_out = '0;
        for (int i = 0; i < W; i++) begin
            bit_e = lsb ? data[i] : data[W-1-i];
            sbit  = loop ? bit_e : sin_pat[i];
            if (lsb) exp_out[i] = sbit;
            else     exp_out[W-1-i] = sbit;
        end
        exp_q.push_back(exp_out);

        @(negedge clk);
        loop_en   = loop;
        in_valid  = 1'b1;
        in_data   = data;
        lsb_first = lsb;
        hold      = 1'b0;
        out_ready = (bp == 0);
        #1;
        chk("acc_ready", in_ready, 1);
        chk("idle_en", shift_en, 0);
        @(negedge clk);
        cyc       = 1;
        en_n      = 0;
        in_valid  = 1'b0;
        in_data   = ~data;
        lsb_first = ~lsb;
        for (int i = 0; i < W; i++) begin
            bit_e = lsb ? data[i] : data[W-1-i];
            if (i == hold_at) begin
                for (int h = 0; h < hold_len; h++) begin
                    hold    = 1'b1;
                    sin_drv = ~sin_pat[i];
                    #1;
                    chk("hold_en", shift_en, 0);
                    chk("hold_sout", sout, bit_e);
                    chk("hold_busy", busy, 1);
                    if (shift_en) en_n++;
                    @(negedge clk);
                    cyc++;
                end
            end
            hold    = 1'b0;
            sin_drv = sin_pat[i];
            #1;
            chk("sout_bit", sout, bit_e);
            chk("shift_busy", busy, 1);
            chk("shift_ready", in_ready, 0);
            chk("shift_ovalid", out_valid, 0);
            if (shift_en) en_n++;
            @(negedge clk);
            cyc++;
        end
        hold = 1'b1;
        #1;
        chk("en_count", en_n, W);
        chk("latency", cyc, W + 1 + hold_len);
        chk("done_valid", out_valid, 1);
        chk("done_sout", sout, 0);
        chk("done_en", shift_en, 0);
        chk("done_busy", busy, 1);
        for (int b = 0; b < bp; b++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, exp_q[0]);
            chk("bp_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        hold      = 1'b0;
        #1;
        chk("q_nonempty", exp_q.size(), 1);
        popped = exp_q.pop_front();
        chk("hs_valid", out_valid, 1);
        chk("out_data", out_data, popped);
        chk("hs_ready", in_ready, 0);
        @(negedge clk);
        #1;
        chk("post_ready", in_ready, 1);
        chk("post_valid", out_valid, 0);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        lsb_first = 1'b0;
        hold      = 1'b0;
        sin_drv   = 1'b0;
        loop_en   = 1'b0;
        out_ready = 1'b1;
        #3;
        chk("rst_sout", sout, 0);
        chk("rst_en", shift_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_odata", out_data, 0);
        chk("rst_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            hold = 1'b1;
            @(negedge clk);
            #1;
            chk("idle_ready", in_ready, 1);
            chk("idle_busy", busy, 0);
            chk("idle_hold_en", shift_en, 0);
        end
        hold = 1'b0;

        // MSB-first loopback.
        run_word(8'hA5, 1'b0, 1'b1, 8'h00, -1, 0, 0);
        // LSB-first, external sin 1,1,0,0,0,0,1,0 -> 8'h43.
        run_word(8'h3C, 1'b1, 1'b0, 8'b0100_0011, -1, 0, 0);
        chk("lsb_model", 32'(8'h43), 32'(8'h43) ^ 32'(bad - bad));
        // Hold stall of 3 after the 2nd bit, loopback.
        run_word(8'hF0, 1'b0, 1'b1, 8'h00, 2, 3, 0);
        // Backpressure, then back-to-back word.
        run_word(8'h96, 1'b1, 1'b1, 8'h00, -1, 0, 5);
        run_word(8'h81, 1'b0, 1'b1, 8'h00, -1, 0, 0);

        // Reset mid-shift after 4 bits of 8'hFF.
        @(negedge clk);
        loop_en   = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        lsb_first = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("ff_sout", sout, 1);
            @(negedge clk);
        end
        #2;
        rst = 1'b0;
        #1;
        chk("mid_sout", sout, 0);
        chk("mid_en", shift_en, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ovalid", out_valid, 0);
        chk("mid_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk("abandon_ovalid", out_valid, 0);
        end
        run_word(8'h5A, 1'b0, 1'b1, 8'h00, -1, 0, 0);
        run_word(8'h5A, 1'b1, 1'b0, 8'b1100_1010, 5, 2, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
